// File: rtl/seq_pkg.sv
// Shared definitions for the serializer feeding the 0001 sequence detector.
// Holds the FSM state encoding, the idle line level and the common word width.
// Imported by the serializer and reused by detector-side benches.
package seq_pkg;

  // Serializer FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Idle level of the serial line; 1 keeps the detector parked in its start state
  localparam logic IDLE_BIT_DEF = 1'b1;

  // Common word width shared with detector-side benches
  localparam int SEQ_WIDTH = 8;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer.sv
// Purpose: parallel-to-serial stage, WIDTH-bit words in, one bit per clock out to the detector.
// Latency: word accepted at edge k in IDLE shows its first bit in cycle k+1, last bit in cycle k+WIDTH.
// Backpressure: din_ready = !hold_full; a one-word holding register lets words stream with no gap.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_WIDTH,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             on_last;
  logic [WIDTH-1:0] shreg_shifted;

  // Handshake: readiness depends only on the holding register, never on din_valid
  assign din_ready = !hold_full_q;
  assign accept    = din_valid && din_ready;
  assign on_last   = (state_q == SHIFT) && (bitcnt_q == LAST_IDX);

  // Shift toward the output end; vacated bits fill with zero and are never observed
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};

  // State register plus datapath registers; reset discards in-flight and held words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Next-state: leave SHIFT only when the last bit goes out with nothing pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (on_last && !hold_full_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load/shift the word, park an early arrival in hold
  always_comb begin
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        // Straight into the shifter; hold stays untouched
        if (accept) begin
          shreg_d  = din;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (!on_last) begin
          shreg_d  = shreg_shifted;
          bitcnt_d = bitcnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Held word wins; din_ready is low so no accept can collide here
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
        end else if (accept) begin
          // Word arriving on the last bit bypasses hold
          shreg_d  = din;
          bitcnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    x        = IDLE_BIT;
    x_valid  = 1'b0;
    last_bit = 1'b0;
    if (state_q == SHIFT) begin
      x        = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
      x_valid  = 1'b1;
      last_bit = (bitcnt_q == LAST_IDX);
    end
  end

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first instance plus an LSB-first instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Cycle c in each task counts cycles after the edge that accepts the first word.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       x;
  logic       x_valid;
  logic       last_bit;

  logic [7:0] din2;
  logic       din2_valid;
  logic       din2_ready;
  logic       x2;
  logic       x2_valid;
  logic       last_bit2;

  int errors = 0;
  int checks = 0;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .last_bit  (last_bit)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din2),
    .din_valid (din2_valid),
    .din_ready (din2_ready),
    .x         (x2),
    .x_valid   (x2_valid),
    .last_bit  (last_bit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    rst_n = 1'b0; din = '0; din_valid = 1'b0; din2 = '0; din2_valid = 1'b0;
    #2;
    got = {x, x_valid, din_ready, last_bit};
    checks++;
    if (got !== 4'b1010) begin
      errors++; $display("FAIL reset_init got=%b exp=1010", got);
    end
    step; rst_n = 1'b1;
    step;
    checks++;
    if (x !== 1'b1 || x_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got x=%b v=%b exp x=1 v=0", x, x_valid);
    end
    // Load a word and fill hold, then reset mid-word
    din = 8'hF0; din_valid = 1'b1; step;
    din = 8'h0F; step;
    din_valid = 1'b0; step; step;
    checks++;
    if (x_valid !== 1'b1 || din_ready !== 1'b0) begin
      errors++; $display("FAIL reset_midword_pre got v=%b rdy=%b exp v=1 rdy=0", x_valid, din_ready);
    end
    #3 rst_n = 1'b0;
    #1;
    got = {x, x_valid, din_ready, last_bit};
    checks++;
    if (got !== 4'b1010) begin
      errors++; $display("FAIL reset_async got=%b exp=1010", got);
    end
    step; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      got = {x, x_valid, din_ready, last_bit};
      checks++;
      if (got !== 4'b1010) begin
        errors++; $display("FAIL reset_release i=%0d got=%b exp=1010", i, got);
      end
    end
  endtask

  task automatic test_single_word;
    logic [7:0] w;
    logic [3:0] det;
    int         zc;
    w = 8'h01; det = 4'b1111; zc = 0;
    din = w; din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      logic ex, ev, el;
      ev = (c <= 8);
      ex = ev ? w[8-c] : 1'b1;
      el = (c == 8);
      checks++;
      if (x !== ex || x_valid !== ev || last_bit !== el) begin
        errors++;
        $display("FAIL single c=%0d got x=%b v=%b l=%b exp x=%b v=%b l=%b", c, x, x_valid, last_bit, ex, ev, el);
      end
      det = {det[2:0], x};
      if (det == 4'b0001) zc++;
      step;
    end
    checks++;
    if (zc != 1) begin
      errors++; $display("FAIL single_detect got=%0d exp=1", zc);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic [3:0]  det;
    int          idx, zc;
    logic        acc;
    words[0] = 8'hF0; words[1] = 8'h0F; words[2] = 8'h81;
    stream = 24'hF00F81;
    det = 4'b1111; zc = 0; idx = 0;
    din = words[0]; din_valid = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      logic ex, ev, el, er;
      acc = din_valid && din_ready;
      step;
      if (acc) idx++;
      din_valid = (idx < 3);
      din       = (idx < 3) ? words[idx] : 8'h00;
      ev = (c <= 24);
      ex = ev ? stream[24-c] : 1'b1;
      el = ev && (c % 8 == 0);
      er = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
      checks++;
      if (x !== ex || x_valid !== ev || last_bit !== el || din_ready !== er) begin
        errors++;
        $display("FAIL b2b c=%0d got x=%b v=%b l=%b rdy=%b exp x=%b v=%b l=%b rdy=%b",
                 c, x, x_valid, last_bit, din_ready, ex, ev, el, er);
      end
      det = {det[2:0], x};
      if (det == 4'b0001) zc++;
    end
    checks++;
    if (zc != 2) begin
      errors++; $display("FAIL b2b_detect got=%0d exp=2", zc);
    end
  endtask

  task automatic test_load_on_last_bit;
    logic [15:0] stream;
    stream = 16'hA53C;
    din = 8'hA5; din_valid = 1'b1;
    step;
    din_valid = 1'b0; din = 8'h3C;
    for (int c = 1; c <= 17; c++) begin
      logic ex, ev, el;
      ev = (c <= 16);
      ex = ev ? stream[16-c] : 1'b1;
      el = (c == 8) || (c == 16);
      checks++;
      if (x !== ex || x_valid !== ev || last_bit !== el || din_ready !== 1'b1) begin
        errors++;
        $display("FAIL lastload c=%0d got x=%b v=%b l=%b rdy=%b exp x=%b v=%b l=%b rdy=1",
                 c, x, x_valid, last_bit, din_ready, ex, ev, el);
      end
      // Present the second word only during the first word's last bit
      din_valid = (c == 8);
      step;
    end
  endtask

  task automatic test_held_blocks_input;
    logic [7:0]  words [3];
    logic [23:0] stream;
    int          idx;
    logic        acc;
    words[0] = 8'h55; words[1] = 8'hC3; words[2] = 8'h99;
    stream = 24'h55C399;
    idx = 0;
    din = words[0]; din_valid = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      logic ex, ev, er;
      acc = din_valid && din_ready;
      step;
      if (acc) idx++;
      // Third word appears while hold is full and must wait for its handshake
      din_valid = (idx < 3) && !(idx == 2 && c < 4);
      din       = (idx < 3) ? words[idx] : 8'h00;
      ev = (c <= 24);
      ex = ev ? stream[24-c] : 1'b1;
      er = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
      checks++;
      if (x !== ex || x_valid !== ev || din_ready !== er) begin
        errors++;
        $display("FAIL held c=%0d got x=%b v=%b rdy=%b exp x=%b v=%b rdy=%b",
                 c, x, x_valid, din_ready, ex, ev, er);
      end
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] w;
    w = 8'h08;
    din2 = w; din2_valid = 1'b1;
    step;
    din2_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      logic ex, ev, el;
      ev = (c <= 8);
      ex = ev ? w[c-1] : 1'b1;
      el = (c == 8);
      checks++;
      if (x2 !== ex || x2_valid !== ev || last_bit2 !== el) begin
        errors++;
        $display("FAIL lsb c=%0d got x=%b v=%b l=%b exp x=%b v=%b l=%b", c, x2, x2_valid, last_bit2, ex, ev, el);
      end
      step;
    end
  endtask

  initial begin
    test_reset;
    step;
    test_single_word;
    step;
    test_back_to_back;
    step; step;
    test_load_on_last_bit;
    step;
    test_held_blocks_input;
    step; step;
    test_lsb_first;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_bit_serializer
